// File: rtl/grn_pkg.sv
// grn_pkg: shared definitions for the Boolean-network node array.
//   GRN_MAX_IN    - largest supported regulator fan-in per node
//   grn_or_lut    - default truth table (OR of all inputs) for n inputs
//   grn_phase_w   - width of the slow-copy phase counter for a divider
package grn_pkg;

  localparam int GRN_MAX_IN = 6;
  localparam int GRN_MAX_LUT_W = 1 << GRN_MAX_IN;

  // Entry 0 (all regulators off) gives 0; every other input vector gives 1.
  // The result is sized for the widest node; callers truncate to 2**n bits.
  function automatic logic [GRN_MAX_LUT_W-1:0] grn_or_lut(input int n);
    logic [GRN_MAX_LUT_W-1:0] t;
    t = '0;
    for (int i = 1; i < GRN_MAX_LUT_W; i++) begin
      if (i < (1 << n)) t[i] = 1'b1;
    end
    return t;
  endfunction

  // Counter holding 0..div-1; at least one bit so SLOW_DIV=1 still builds.
  function automatic int grn_phase_w(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/grn_node_lut_if.sv
// grn_node_lut_if: strobe, configuration and state bus of one network node.
//   master - array controller / neighbours: drive strobes, config, regulators
//   slave  - the node: drives s0/s1, upd_s0/upd_s1, match (and flips)
// Macro GRN_NODE_FLIPS_EN adds the flips transition counter signal.
interface grn_node_lut_if
  import grn_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int CNT_W  = 8
);
  localparam int LUT_W = 2 ** NUM_IN;

  if (NUM_IN < 1 || NUM_IN > GRN_MAX_IN || CNT_W < 1) begin : g_param_bad
    $error("grn_node_lut_if: NUM_IN must be 1..%0d and CNT_W >= 1", GRN_MAX_IN);
  end

  logic              reset_nos;
  logic              init_state;
  logic              cfg_we;
  logic [LUT_W-1:0]  cfg_lut;
  logic              start_s0;
  logic              start_s1;
  logic [NUM_IN-1:0] in_s0;
  logic [NUM_IN-1:0] in_s1;
  logic              s0;
  logic              s1;
  logic              upd_s0;
  logic              upd_s1;
  logic              match;
`ifdef GRN_NODE_FLIPS_EN
  logic [CNT_W-1:0]  flips;

  modport master (
    output reset_nos, init_state, cfg_we, cfg_lut, start_s0, start_s1, in_s0, in_s1,
    input  s0, s1, upd_s0, upd_s1, match, flips
  );
  modport slave (
    input  reset_nos, init_state, cfg_we, cfg_lut, start_s0, start_s1, in_s0, in_s1,
    output s0, s1, upd_s0, upd_s1, match, flips
  );
`else
  modport master (
    output reset_nos, init_state, cfg_we, cfg_lut, start_s0, start_s1, in_s0, in_s1,
    input  s0, s1, upd_s0, upd_s1, match
  );
  modport slave (
    input  reset_nos, init_state, cfg_we, cfg_lut, start_s0, start_s1, in_s0, in_s1,
    output s0, s1, upd_s0, upd_s1, match
  );
`endif

endinterface

// File: rtl/grn_lut_eval.sv
// grn_lut_eval: combinational truth-table lookup, value = lut[index].
//   lut   - 2**NUM_IN entry truth table
//   index - regulator state vector (bit 0 is the LSB of the index)
//   value - selected next state
module grn_lut_eval #(
  parameter int NUM_IN = 4
) (
  input  logic [2**NUM_IN-1:0] lut,
  input  logic [NUM_IN-1:0]    index,
  output logic                 value
);

  assign value = lut[index];

endmodule

// File: rtl/grn_node_lut.sv
// grn_node_lut: Boolean-network node with a slow (s0) and a fast (s1) copy of
// one gene state for tortoise/hare attractor detection. The next state comes
// from a runtime-loadable truth table; s0 advances once per SLOW_DIV start_s0
// strobes, s1 on every start_s1 strobe.
//   clk, rst (sync, active-high)
//   bus (slave) - reset_nos/init_state restart, cfg_we/cfg_lut table load,
//                 start_s0/start_s1 strobes, in_s0/in_s1 regulators,
//                 s0/s1 states, upd_s0/upd_s1 pulses, match, flips
// Macro GRN_NODE_FLIPS_EN adds the saturating flips counter on s1 changes.
module grn_node_lut
  import grn_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int SLOW_DIV = 2,
  parameter int CNT_W    = 8
) (
  input logic           clk,
  input logic           rst,
  grn_node_lut_if.slave bus
);

  localparam int LUT_W = 2 ** NUM_IN;
  localparam int PH_W  = grn_phase_w(SLOW_DIV);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(SLOW_DIV - 1);
  localparam logic [LUT_W-1:0] LUT_RST = LUT_W'(grn_or_lut(NUM_IN));

  if (NUM_IN < 1 || NUM_IN > GRN_MAX_IN || SLOW_DIV < 1 || SLOW_DIV > 8 || CNT_W < 1)
  begin : g_param_bad
    $error("grn_node_lut: parameter out of range");
  end

  logic [LUT_W-1:0] lut;
  logic [PH_W-1:0]  phase;
  logic             s0_q;
  logic             s1_q;
  logic             upd_s0_q;
  logic             upd_s1_q;
  logic             next_s0;
  logic             next_s1;

  grn_lut_eval #(.NUM_IN(NUM_IN)) u_eval_s0 (
    .lut   (lut),
    .index (bus.in_s0),
    .value (next_s0)
  );

  grn_lut_eval #(.NUM_IN(NUM_IN)) u_eval_s1 (
    .lut   (lut),
    .index (bus.in_s1),
    .value (next_s1)
  );

  // A step in the same cycle as cfg_we still sees the old table because the
  // lookups read the register, not cfg_lut.
  always_ff @(posedge clk) begin
    if (rst) begin
      lut <= LUT_RST;
    end else if (bus.cfg_we) begin
      lut <= bus.cfg_lut;
    end
  end

  // Restart parks phase at the last count so the first slow strobe after a
  // network restart updates s0 immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q     <= 1'b0;
      s1_q     <= 1'b0;
      phase    <= '0;
      upd_s0_q <= 1'b0;
      upd_s1_q <= 1'b0;
    end else if (bus.reset_nos) begin
      s0_q     <= bus.init_state;
      s1_q     <= bus.init_state;
      phase    <= PH_LAST;
      upd_s0_q <= 1'b0;
      upd_s1_q <= 1'b0;
    end else begin
      upd_s0_q <= 1'b0;
      upd_s1_q <= 1'b0;
      if (bus.start_s0) begin
        if (phase == PH_LAST) begin
          s0_q     <= next_s0;
          phase    <= '0;
          upd_s0_q <= 1'b1;
        end else begin
          phase <= phase + PH_W'(1);
        end
      end
      if (bus.start_s1) begin
        s1_q     <= next_s1;
        upd_s1_q <= 1'b1;
      end
    end
  end

  assign bus.s0     = s0_q;
  assign bus.s1     = s1_q;
  assign bus.upd_s0 = upd_s0_q;
  assign bus.upd_s1 = upd_s1_q;
  assign bus.match  = (s0_q == s1_q);

`ifdef GRN_NODE_FLIPS_EN
  logic [CNT_W-1:0] flips_q;

  always_ff @(posedge clk) begin
    if (rst || bus.reset_nos) begin
      flips_q <= '0;
    end else if (bus.start_s1 && (next_s1 != s1_q) && (flips_q != {CNT_W{1'b1}})) begin
      flips_q <= flips_q + CNT_W'(1);
    end
  end

  assign bus.flips = flips_q;
`endif

endmodule
